// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, out_sel encodings, writeback states and opcode classes shared with the ALU
package cpu_pkg;
  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_ALU_LAST = 5'b01110;
  localparam logic [4:0] OP_DIV = 5'b01111;
  localparam logic [4:0] OP_MUL = 5'b10000;
  localparam logic [4:0] OP_NEG = 5'b10001;
  localparam logic [4:0] OP_NOT = 5'b10010;
  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_LO = 2'b01;
  localparam logic [1:0] SEL_HI = 2'b10;
  typedef enum logic [1:0] {IDLE, SEND_Z, SEND_LO, SEND_HI} wb_state_t;
  typedef struct packed {
    logic single;
    logic dbl;
    logic illegal;
  } op_class_t;
endpackage

// File: rtl/z_writeback_if.sv
// z_writeback_if: result-in (in_valid/in_ready/alu_c/opcode) and beat-out (out_valid/out_ready/out_data/out_sel) handshakes; master = producer/consumer side, slave = z_writeback
interface z_writeback_if #(parameter int DATA_W = 32);
  logic in_valid;
  logic in_ready;
  logic [2*DATA_W-1:0] alu_c;
  logic [4:0] opcode;
  logic out_valid;
  logic out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0] out_sel;
  modport master(output in_valid, alu_c, opcode, out_ready, input in_ready, out_valid, out_data, out_sel);
  modport slave(input in_valid, alu_c, opcode, out_ready, output in_ready, out_valid, out_data, out_sel);
endinterface

// File: rtl/z_writeback_opcode_class.sv
// opcode_class: maps opcode (in) to {single, dbl, illegal} (out cls)
module opcode_class
  import cpu_pkg::*;
(
  input  logic [4:0] opcode,
  output op_class_t  cls
);
  always_comb begin
    cls.single = (opcode >= OP_ADD && opcode <= OP_ALU_LAST) || opcode == OP_NEG || opcode == OP_NOT;
    cls.dbl = opcode == OP_MUL || opcode == OP_DIV;
    cls.illegal = !cls.single && !cls.dbl;
  end
endmodule

// File: rtl/z_writeback.sv
// z_writeback: streams ALU results as LO/HI beats; ports clock, clear (async), bus (slave), illegal pulse, done_count
module z_writeback
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                 clock,
  input  logic                 clear,
  z_writeback_if.slave         bus,
  output logic                 illegal,
  output logic [15:0]          done_count
);
  wb_state_t state, state_n;
  op_class_t cls;
  logic [DATA_W-1:0] data_q, hi_q;
  logic accept, xfer;
  opcode_class u_cls (.opcode(bus.opcode), .cls(cls));
  assign accept = bus.in_valid && bus.in_ready;
  assign xfer = bus.out_valid && bus.out_ready;
  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    if (state == IDLE && accept) state_n = cls.single ? SEND_Z : cls.dbl ? SEND_LO : IDLE;
    else if (xfer) state_n = state == SEND_LO ? SEND_HI : IDLE;
  end
  always_comb begin
    bus.in_ready = state == IDLE;
    bus.out_valid = state != IDLE;
    bus.out_sel = state == IDLE ? SEL_NONE : state == SEND_HI ? SEL_HI : SEL_LO;
  end
  // data_q is both the LO capture and the out_data register; it takes the HI word on the LO transfer
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      data_q <= '0;
      hi_q <= '0;
      illegal <= 1'b0;
      done_count <= '0;
    end else begin
      illegal <= accept && cls.illegal;
      if (accept) begin
        data_q <= bus.alu_c[DATA_W-1:0];
        hi_q <= bus.alu_c[2*DATA_W-1:DATA_W];
      end else if (xfer && state == SEND_LO) data_q <= hi_q;
      if (xfer && state != SEND_LO) done_count <= done_count + 16'd1;
    end
  end
  assign bus.out_data = data_q;
endmodule

// File: tb/tb_z_writeback.sv
// tb_z_writeback: directed and randomized self-checking bench for z_writeback
module tb_z_writeback;
  localparam int W = 32;
  typedef struct {
    logic [31:0] d;
    logic [1:0]  s;
    bit          last;
  } beat_t;
  logic clock = 0, clear = 1;
  logic illegal;
  logic [15:0] done_count;
  logic [15:0] exp_cnt = 0;
  int checks = 0, errors = 0;
  z_writeback_if #(.DATA_W(W)) bus ();
  z_writeback #(.DATA_W(W)) dut (.clock(clock), .clear(clear), .bus(bus.slave), .illegal(illegal), .done_count(done_count));
  always #5 clock = ~clock;

  function automatic int kind(input logic [4:0] op);
    if ((op >= 3 && op <= 14) || op == 17 || op == 18) return 1;
    if (op == 15 || op == 16) return 2;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic put(input logic [4:0] op, input logic [63:0] c);
    bus.opcode = op;
    bus.alu_c = c;
    bus.in_valid = 1;
  endtask

  task automatic test_reset();
    bus.in_valid = 0;
    bus.out_ready = 1;
    bus.opcode = 0;
    bus.alu_c = 0;
    clear = 1;
    tick();
    checks++;
    if (bus.out_valid !== 0 || bus.out_sel !== 2'b00 || bus.out_data !== 0 || illegal !== 0 || done_count !== 0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b s=%b d=%h ill=%b cnt=%h want 0 0 0 0 0", bus.out_valid, bus.out_sel, bus.out_data, illegal, done_count);
    end
    @(negedge clock);
    clear = 0;
    #1;
    checks++;
    if (bus.in_ready !== 1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_add();
    bus.out_ready = 1;
    put(5'b00011, 64'h2A);
    tick();
    bus.in_valid = 0;
    checks++;
    if (bus.out_valid !== 1 || bus.out_sel !== 2'b01 || bus.out_data !== 32'h2A) begin
      errors++;
      $display("FAIL add_beat got v=%b s=%b d=%h want 1 01 0000002a", bus.out_valid, bus.out_sel, bus.out_data);
    end
    checks++;
    if (bus.in_ready !== 0) begin
      errors++;
      $display("FAIL add_busy got in_ready=%b want 0", bus.in_ready);
    end
    tick();
    exp_cnt++;
    checks++;
    if (bus.out_valid !== 0 || bus.in_ready !== 1 || done_count !== exp_cnt) begin
      errors++;
      $display("FAIL add_done got v=%b rdy=%b cnt=%h want 0 1 %h", bus.out_valid, bus.in_ready, done_count, exp_cnt);
    end
  endtask

  task automatic test_multiply();
    bus.out_ready = 1;
    put(5'b10000, 64'h00000001_80000000);
    tick();
    bus.in_valid = 0;
    checks++;
    if (bus.out_valid !== 1 || bus.out_sel !== 2'b01 || bus.out_data !== 32'h80000000 || done_count !== exp_cnt) begin
      errors++;
      $display("FAIL mul_lo got v=%b s=%b d=%h cnt=%h want 1 01 80000000 %h", bus.out_valid, bus.out_sel, bus.out_data, done_count, exp_cnt);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1 || bus.out_sel !== 2'b10 || bus.out_data !== 32'h1 || done_count !== exp_cnt) begin
      errors++;
      $display("FAIL mul_hi got v=%b s=%b d=%h cnt=%h want 1 10 00000001 %h", bus.out_valid, bus.out_sel, bus.out_data, done_count, exp_cnt);
    end
    tick();
    exp_cnt++;
    checks++;
    if (bus.out_valid !== 0 || bus.in_ready !== 1 || done_count !== exp_cnt) begin
      errors++;
      $display("FAIL mul_done got v=%b rdy=%b cnt=%h want 0 1 %h", bus.out_valid, bus.in_ready, done_count, exp_cnt);
    end
  endtask

  task automatic test_divide_stall();
    bus.out_ready = 0;
    put(5'b01111, 64'h00000003_00000007);
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.in_valid = 0;
      checks++;
      if (bus.out_valid !== 1 || bus.out_sel !== 2'b01 || bus.out_data !== 32'h7) begin
        errors++;
        $display("FAIL div_lo_hold%0d got v=%b s=%b d=%h want 1 01 00000007", i, bus.out_valid, bus.out_sel, bus.out_data);
      end
    end
    bus.out_ready = 1;
    tick();
    checks++;
    if (bus.out_valid !== 1 || bus.out_sel !== 2'b10 || bus.out_data !== 32'h3) begin
      errors++;
      $display("FAIL div_hi got v=%b s=%b d=%h want 1 10 00000003", bus.out_valid, bus.out_sel, bus.out_data);
    end
    tick();
    exp_cnt++;
    checks++;
    if (bus.out_valid !== 0 || done_count !== exp_cnt) begin
      errors++;
      $display("FAIL div_done got v=%b cnt=%h want 0 %h", bus.out_valid, done_count, exp_cnt);
    end
  endtask

  task automatic test_illegal();
    bus.out_ready = 1;
    put(5'b11111, 64'hDEAD_BEEF_CAFE_F00D);
    tick();
    bus.in_valid = 0;
    checks++;
    if (illegal !== 1 || bus.out_valid !== 0 || bus.in_ready !== 1) begin
      errors++;
      $display("FAIL ill_pulse got ill=%b v=%b rdy=%b want 1 0 1", illegal, bus.out_valid, bus.in_ready);
    end
    tick();
    checks++;
    if (illegal !== 0 || bus.out_valid !== 0 || done_count !== exp_cnt) begin
      errors++;
      $display("FAIL ill_after got ill=%b v=%b cnt=%h want 0 0 %h", illegal, bus.out_valid, done_count, exp_cnt);
    end
  endtask

  task automatic test_random();
    beat_t q[$];
    beat_t b;
    bit acc = 0, exp_ill = 0;
    int n = 0;
    bus.in_valid = 0;
    for (int cyc = 0; cyc < 4000 && (n < 200 || q.size() != 0 || bus.in_valid); cyc++) begin
      @(negedge clock);
      checks++;
      if (bus.out_valid !== (q.size() != 0) || bus.in_ready !== (q.size() == 0)) begin
        errors++;
        $display("FAIL rnd_hs cyc %0d got v=%b rdy=%b want busy=%0d", cyc, bus.out_valid, bus.in_ready, q.size() != 0);
      end
      checks++;
      if (illegal !== exp_ill || done_count !== exp_cnt) begin
        errors++;
        $display("FAIL rnd_status cyc %0d got ill=%b cnt=%h want %b %h", cyc, illegal, done_count, exp_ill, exp_cnt);
      end
      if (q.size() != 0) begin
        checks++;
        if (bus.out_data !== q[0].d || bus.out_sel !== q[0].s) begin
          errors++;
          $display("FAIL rnd_beat cyc %0d got d=%h s=%b want %h %b", cyc, bus.out_data, bus.out_sel, q[0].d, q[0].s);
        end
      end
      if (acc) bus.in_valid = 0;
      acc = 0;
      exp_ill = 0;
      if (!bus.in_valid && n < 200 && $urandom_range(0, 2) != 0) begin
        put(5'($urandom_range(0, 31)), {$urandom, $urandom});
        n++;
      end
      bus.out_ready = $urandom_range(0, 3) != 0;
      if (q.size() != 0) begin
        if (bus.out_ready) begin
          b = q.pop_front();
          if (b.last) exp_cnt++;
        end
      end else if (bus.in_valid) begin
        acc = 1;
        case (kind(bus.opcode))
          1: q.push_back(beat_t'{bus.alu_c[31:0], 2'b01, 1'b1});
          2: begin
            q.push_back(beat_t'{bus.alu_c[31:0], 2'b01, 1'b0});
            q.push_back(beat_t'{bus.alu_c[63:32], 2'b10, 1'b1});
          end
          default: exp_ill = 1;
        endcase
      end
    end
    checks++;
    if (n != 200 || q.size() != 0) begin
      errors++;
      $display("FAIL rnd_timeout got sent=%0d pending=%0d want 200 0", n, q.size());
    end
  endtask

  task automatic test_clear_mid_hi();
    @(negedge clock);
    bus.out_ready = 1;
    put(5'b10000, 64'h12345678_9ABCDEF0);
    tick();
    bus.in_valid = 0;
    tick();
    checks++;
    if (bus.out_sel !== 2'b10 || bus.out_valid !== 1) begin
      errors++;
      $display("FAIL clr_pre got v=%b s=%b want 1 10", bus.out_valid, bus.out_sel);
    end
    #2 clear = 1;
    #1;
    exp_cnt = 0;
    checks++;
    if (bus.out_valid !== 0 || bus.out_sel !== 2'b00 || bus.out_data !== 0 || done_count !== 0) begin
      errors++;
      $display("FAIL clr_async got v=%b s=%b d=%h cnt=%h want 0 00 0 0", bus.out_valid, bus.out_sel, bus.out_data, done_count);
    end
    @(negedge clock);
    clear = 0;
    #1;
    checks++;
    if (bus.in_ready !== 1) begin
      errors++;
      $display("FAIL clr_ready got %b want 1", bus.in_ready);
    end
    tick();
    checks++;
    if (bus.out_valid !== 0 || done_count !== 0) begin
      errors++;
      $display("FAIL clr_abandon got v=%b cnt=%h want 0 0", bus.out_valid, done_count);
    end
  endtask

  task automatic test_wrap();
    @(negedge clock);
    force dut.done_count = 16'hFFFE;
    #1;
    release dut.done_count;
    bus.out_ready = 1;
    for (int i = 0; i < 2; i++) begin
      put(5'b00100, 64'(i));
      tick();
      bus.in_valid = 0;
      tick();
    end
    checks++;
    if (done_count !== 16'h0000) begin
      errors++;
      $display("FAIL wrap got cnt=%h want 0000", done_count);
    end
    put(5'b00011, 64'h5);
    tick();
    bus.in_valid = 0;
    tick();
    checks++;
    if (done_count !== 16'h0001) begin
      errors++;
      $display("FAIL wrap_next got cnt=%h want 0001", done_count);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_multiply();
    test_divide_stall();
    test_illegal();
    test_random();
    test_clear_mid_hi();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/z_writeback.md
Z_WRITEBACK -- requirements
Module: z_writeback

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the width of one bus beat and of each result half.
REQ-002 The block SHALL have port clock, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port clear, input, 1, an asynchronous active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1, meaning the ALU result and opcode are presented.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the block accepts a result this cycle.
REQ-006 The block SHALL have port alu_c, input, 2*DATA_W, the 64-bit ALU result C.
REQ-007 The block SHALL have port opcode, input, 5, the operation code that produced alu_c.
REQ-008 The block SHALL have port out_valid, output, 1, meaning the out_data beat is valid.
REQ-009 The block SHALL have port out_ready, input, 1, meaning the bus or register file consumes the beat.
REQ-010 The block SHALL have port out_data, output, DATA_W, the beat payload.
REQ-011 The block SHALL have port out_sel, output, 2, the beat destination: 00 = none, 01 = Z/LO word, 10 = HI word.
REQ-012 The block SHALL have port illegal, output, 1, a one-cycle pulse on acceptance of an unsupported opcode.
REQ-013 The block SHALL have port done_count, output, 16, the count of completed results.

Function
REQ-014 The block SHALL implement the states IDLE, SEND_Z, SEND_LO and SEND_HI.
REQ-015 The block SHALL drive in_ready = 1 only in IDLE.
REQ-016 The block SHALL accept a result when in_valid && in_ready, registering alu_c and opcode.
REQ-017 On acceptance of a single-word opcode, the block SHALL go from IDLE to SEND_Z and drive out_data = alu_c[31:0], out_sel = 01.
REQ-018 The single-word opcodes SHALL be 00011 through 01110, 10001 and 10010.
REQ-019 On acceptance of Multiply (10000) or Divide (01111), the block SHALL go from IDLE to SEND_LO and drive out_data = alu_c[31:0], out_sel = 01.
REQ-020 From SEND_LO with out_ready = 1, the block SHALL go to SEND_HI and drive out_data = alu_c[63:32], out_sel = 10.
REQ-021 The Divide HI word SHALL be the remainder and the LO word SHALL be the quotient.
REQ-022 On acceptance of any other opcode, the block SHALL stay in IDLE, drive no beat, pulse illegal for exactly one cycle, and leave done_count unchanged.
REQ-023 The block SHALL drive out_valid = 1 in SEND_Z, SEND_LO and SEND_HI.
REQ-024 A beat SHALL transfer only on a cycle with out_valid && out_ready.
REQ-025 While out_ready = 0, the block SHALL hold out_data and out_sel stable.
REQ-026 From SEND_Z or SEND_HI, a transfer SHALL return the block to IDLE and increment done_count by 1.
REQ-027 done_count SHALL wrap from 0xFFFF to 0x0000.
REQ-028 Latency SHALL be: acceptance at edge N gives the first beat valid after edge N; with out_ready held at 1, a two-beat result returns to IDLE at edge N+2.
REQ-029 The block SHALL register all outputs; in_ready, out_valid and out_sel SHALL decode from the state register only.
REQ-030 While not in IDLE, the block SHALL ignore in_valid; the producer holds its result until in_ready.

Reset
REQ-031 When clear = 1, the block SHALL immediately enter IDLE.
REQ-032 When clear = 1, the block SHALL drive out_valid = 0, out_data = 0, out_sel = 00, illegal = 0 and done_count = 0.
REQ-033 When clear = 1, the block SHALL clear the captured result registers to 0.
REQ-034 Reset during SEND_LO or SEND_HI SHALL abandon the result with no further beats and no done_count increment.
REQ-035 After clear deasserts, in_ready SHALL be 1 in the first cycle.

Structure
REQ-036 A shared package cpu_pkg SHALL hold the 5-bit opcode constants, the out_sel encodings and the state enumeration, for reuse with the ALU.
REQ-037 A sub-module opcode_class SHALL map opcode to {single, double, illegal}; the FSM, capture registers and counter SHALL reside in z_writeback.

Verification
REQ-038 Verification SHALL cover: Add with alu_c = 0x00000000_0000002A, out_ready = 1 -> one beat 0x2A with out_sel = 01, then IDLE; done_count = 1.
REQ-039 Verification SHALL cover: Multiply with alu_c = 0x00000001_80000000 -> beat 0x80000000/01, then beat 0x00000001/10; done_count increments once.
REQ-040 Verification SHALL cover: Divide with alu_c = 0x00000003_00000007 and out_ready = 0 for 3 cycles -> LO beat 7 held stable for 4 cycles, then HI beat 3.
REQ-041 Verification SHALL cover: opcode 11111 accepted -> illegal high for exactly one cycle, no out_valid, done_count unchanged.
REQ-042 Verification SHALL cover: clear asserted mid-SEND_HI -> out_valid = 0 asynchronously, done_count = 0, in_ready = 1 after release.
REQ-043 Verification SHALL cover: done_count preset by 65535 single-word results plus one more -> done_count = 0x0000.
